// File: rtl/ebpf_addsub_issue.sv
// ebpf_addsub_issue: two-register issue/retire stage around the 64-bit
// add/sub unit. S1 holds the selected operands and drives the unit
// directly; S2 captures the width-corrected result for writeback.
// Optional macro ADDSUB_ISSUE_FLAGS_EN adds registered out_zero/out_neg.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holding valid keeps its data stable until ready is seen;
// ready never depends on the same-side valid. S2 advances when S1 holds
// an op and S2 is empty or draining; S1 accepts when empty or advancing.
module ebpf_addsub_issue #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_alu64,
    input  logic             in_use_imm,
    input  logic [63:0]      in_dst,
    input  logic [63:0]      in_src,
    input  logic [31:0]      in_imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic [63:0]      add_a,
    output logic [63:0]      add_b,
    output logic             add_sub,
    input  logic [63:0]      add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic             out_carry,
`ifdef ADDSUB_ISSUE_FLAGS_EN
    output logic             out_zero,
    output logic             out_neg,
`endif
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_NEG = 2'b10;
    localparam logic [1:0] OP_MOV = 2'b11;

    logic             s1_valid;
    logic             s1_alu64;
    logic             s1_mov;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_adv;
    logic             accept;

    logic [63:0]      src_sel;
    logic [63:0]      raw_a;
    logic [63:0]      raw_b;
    logic             nxt_sub;
    logic [63:0]      nxt_a;
    logic [63:0]      nxt_b;

    logic [63:0]      res_w;
    logic             carry_w;

    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;

    // Operand selection: map the op onto (a, b, sub) and zero-extend for ALU32.
    always_comb begin
        src_sel = in_use_imm ? {{32{in_imm[31]}}, in_imm} : in_src;
        raw_a   = 64'd0;
        raw_b   = 64'd0;
        nxt_sub = 1'b0;
        case (in_op)
            OP_ADD: begin raw_a = in_dst; raw_b = src_sel; nxt_sub = 1'b0; end
            OP_SUB: begin raw_a = in_dst; raw_b = src_sel; nxt_sub = 1'b1; end
            OP_NEG: begin raw_a = 64'd0;  raw_b = in_dst;  nxt_sub = 1'b1; end
            OP_MOV: begin raw_a = 64'd0;  raw_b = src_sel; nxt_sub = 1'b0; end
            default: begin raw_a = 64'd0; raw_b = 64'd0;   nxt_sub = 1'b0; end
        endcase
        nxt_a = in_alu64 ? raw_a : {32'd0, raw_a[31:0]};
        nxt_b = in_alu64 ? raw_b : {32'd0, raw_b[31:0]};
    end

    // S1: operand register feeding the add/sub unit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            add_a    <= 64'd0;
            add_b    <= 64'd0;
            add_sub  <= 1'b0;
            s1_alu64 <= 1'b0;
            s1_mov   <= 1'b0;
            s1_tag   <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                add_a    <= nxt_a;
                add_b    <= nxt_b;
                add_sub  <= nxt_sub;
                s1_alu64 <= in_alu64;
                s1_mov   <= (in_op == OP_MOV);
                s1_tag   <= in_tag;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Width correction of the unit's result and carry / no-borrow.
    always_comb begin
        res_w = s1_alu64 ? add_sum : {32'd0, add_sum[31:0]};
        if (s1_mov)
            carry_w = 1'b0;
        else if (s1_alu64)
            carry_w = add_cout;
        else
            carry_w = add_sum[32] ^ add_sub;
    end

    // S2: registered result for writeback; drains only when not refilled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= 64'd0;
            out_carry  <= 1'b0;
            out_tag    <= '0;
        end else begin
            if (s2_adv) begin
                out_valid  <= 1'b1;
                out_result <= res_w;
                out_carry  <= carry_w;
                out_tag    <= s1_tag;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

`ifdef ADDSUB_ISSUE_FLAGS_EN
    // Zero / sign flags of the width-masked result, captured with S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
        end else if (s2_adv) begin
            out_zero <= (res_w == 64'd0);
            out_neg  <= s1_alu64 ? res_w[63] : res_w[31];
        end
    end
`endif

endmodule

// File: tb/tb_ebpf_addsub_issue.sv
// Directed bench for ebpf_addsub_issue. Contains a behavioural stand-in
// for the external add/sub unit (a + (sub ? ~b : b) + sub, 65-bit).
module tb_ebpf_addsub_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_alu64;
    logic        in_use_imm;
    logic [63:0] in_dst;
    logic [63:0] in_src;
    logic [31:0] in_imm;
    logic [3:0]  in_tag;
    logic [63:0] add_a;
    logic [63:0] add_b;
    logic        add_sub;
    logic [63:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_carry;
    logic [3:0]  out_tag;
`ifdef ADDSUB_ISSUE_FLAGS_EN
    logic        out_zero;
    logic        out_neg;
`endif

    int errors = 0;
    int checks = 0;

    // Expected results: {carry, tag[3:0], result[63:0]}
    logic [68:0] exp_q[$];
    logic [68:0] exp_e;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] NEG = 2'b10;
    localparam logic [1:0] MOV = 2'b11;

    ebpf_addsub_issue #(.TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_alu64   (in_alu64),
        .in_use_imm (in_use_imm),
        .in_dst     (in_dst),
        .in_src     (in_src),
        .in_imm     (in_imm),
        .in_tag     (in_tag),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sub    (add_sub),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
`ifdef ADDSUB_ISSUE_FLAGS_EN
        .out_zero   (out_zero),
        .out_neg    (out_neg),
`endif
        .out_tag    (out_tag)
    );

    // External add/sub unit model.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, (add_sub ? ~add_b : add_b)}
                               + {64'd0, add_sub};

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk64(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic chk1(input string name, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", name, obs, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic a64, input logic ui,
                         input logic [63:0] dst, input logic [63:0] src,
                         input logic [31:0] imm, input logic [3:0] tag);
        in_valid   = 1'b1;
        in_op      = op;
        in_alu64   = a64;
        in_use_imm = ui;
        in_dst     = dst;
        in_src     = src;
        in_imm     = imm;
        in_tag     = tag;
    endtask

    // One op with out_ready=1: accepted on the first edge, visible two edges later.
    task automatic run_one(input string name, input logic [1:0] op, input logic a64,
                           input logic ui, input logic [63:0] dst, input logic [63:0] src,
                           input logic [31:0] imm, input logic [3:0] tag,
                           input logic [63:0] exp_res, input logic exp_c);
        @(negedge clk);
        chk1({name, ".in_ready"}, in_ready, 1'b1);
        drive(op, a64, ui, dst, src, imm, tag);
        @(negedge clk);
        in_valid = 1'b0;
        chk1({name, ".early_valid"}, out_valid, 1'b0);
        @(negedge clk);
        chk1({name, ".out_valid"}, out_valid, 1'b1);
        chk64({name, ".result"}, out_result, exp_res);
        chk1({name, ".carry"}, out_carry, exp_c);
        chk4({name, ".tag"}, out_tag, tag);
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        drive(ADD, 1'b1, 1'b0, 64'd0, 64'd0, 32'd0, 4'd0);
        in_valid = 1'b0;

        // Reset state.
        @(negedge clk);
        chk1("rst.out_valid", out_valid, 1'b0);
        chk1("rst.in_ready", in_ready, 1'b1);
        chk64("rst.out_result", out_result, 64'd0);
        chk1("rst.out_carry", out_carry, 1'b0);
        chk4("rst.out_tag", out_tag, 4'd0);
        chk64("rst.add_a", add_a, 64'd0);
        chk64("rst.add_b", add_b, 64'd0);
        chk1("rst.add_sub", add_sub, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single ops, hand-computed results.
        run_one("add64_wrap", ADD, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'd0, 4'd3,
                64'd0, 1'b1);
`ifdef ADDSUB_ISSUE_FLAGS_EN
        chk1("add64_wrap.zero", out_zero, 1'b1);
        chk1("add64_wrap.neg", out_neg, 1'b0);
`endif
        run_one("sub32_imm", SUB, 1'b0, 1'b1, 64'h1234_0000_0000_0005, 64'hDEAD, 32'd7, 4'd2,
                64'h0000_0000_FFFF_FFFE, 1'b0);
`ifdef ADDSUB_ISSUE_FLAGS_EN
        chk1("sub32_imm.zero", out_zero, 1'b0);
        chk1("sub32_imm.neg", out_neg, 1'b1);
`endif
        run_one("neg64", NEG, 1'b1, 1'b0, 64'd5, 64'h99, 32'd0, 4'd7,
                64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        run_one("mov32_imm", MOV, 1'b0, 1'b1, 64'h1111, 64'h2222, 32'hFFFF_FFFF, 4'd10,
                64'h0000_0000_FFFF_FFFF, 1'b0);
        run_one("add32_carry", ADD, 1'b0, 1'b0, 64'hAAAA_0000_FFFF_FFFF, 64'h5555_0000_0000_0001,
                32'd0, 4'd4, 64'd0, 1'b1);
        run_one("sub64_noborrow", SUB, 1'b1, 1'b0, 64'd10, 64'd3, 32'd0, 4'd5, 64'd7, 1'b1);
        run_one("add64_simm", ADD, 1'b1, 1'b1, 64'h100, 64'h0, 32'hFFFF_FFFF, 4'd6,
                64'hFF, 1'b1);
        run_one("neg32", NEG, 1'b0, 1'b0, 64'hDEAD_0000_0000_0001, 64'h0, 32'd0, 4'd8,
                64'h0000_0000_FFFF_FFFF, 1'b0);
        run_one("mov64_reg", MOV, 1'b1, 1'b0, 64'h7, 64'h0123_4567_89AB_CDEF, 32'd0, 4'd9,
                64'h0123_4567_89AB_CDEF, 1'b0);
        run_one("sub32_equal", SUB, 1'b0, 1'b0, 64'h9_0000_0042, 64'h42, 32'd0, 4'd1,
                64'd0, 1'b1);

        // Back-to-back: four ops, one result per cycle after two cycles.
        exp_q.push_back({1'b0, 4'd1, 64'd3});
        exp_q.push_back({1'b0, 4'd2, 64'hFFFF_FFFF_FFFF_FFFD});
        exp_q.push_back({1'b0, 4'd4, 64'h55});
        exp_q.push_back({1'b1, 4'd5, 64'd0});
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4) chk1("b2b.in_ready", in_ready, 1'b1);
            case (k)
                0: drive(ADD, 1'b1, 1'b0, 64'd1, 64'd2, 32'd0, 4'd1);
                1: drive(SUB, 1'b1, 1'b0, 64'd2, 64'd5, 32'd0, 4'd2);
                2: drive(MOV, 1'b1, 1'b0, 64'd9, 64'h55, 32'd0, 4'd4);
                3: drive(ADD, 1'b0, 1'b0, 64'h8000_0000, 64'h8000_0000, 32'd0, 4'd5);
                default: in_valid = 1'b0;
            endcase
            if (k >= 2) begin
                exp_e = exp_q.pop_front();
                chk1("b2b.out_valid", out_valid, 1'b1);
                chk64("b2b.result", out_result, exp_e[63:0]);
                chk4("b2b.tag", out_tag, exp_e[67:64]);
                chk1("b2b.carry", out_carry, exp_e[68]);
            end
        end
        @(negedge clk);
        chk1("b2b.drained", out_valid, 1'b0);

        // Backpressure: three ops offered while out_ready=0.
        out_ready = 1'b0;
        chk1("bp.in_ready0", in_ready, 1'b1);
        drive(ADD, 1'b1, 1'b0, 64'd10, 64'd20, 32'd0, 4'd6);
        @(negedge clk);
        chk1("bp.in_ready1", in_ready, 1'b1);
        drive(SUB, 1'b1, 1'b0, 64'd100, 64'd1, 32'd0, 4'd7);
        @(negedge clk);
        chk1("bp.in_ready2", in_ready, 1'b0);
        chk1("bp.valid2", out_valid, 1'b1);
        chk64("bp.result2", out_result, 64'd30);
        chk4("bp.tag2", out_tag, 4'd6);
        drive(MOV, 1'b1, 1'b0, 64'd0, 64'h77, 32'd0, 4'd8);
        @(negedge clk);
        chk1("bp.in_ready3", in_ready, 1'b0);
        chk1("bp.valid3", out_valid, 1'b1);
        chk64("bp.result3", out_result, 64'd30);
        chk4("bp.tag3", out_tag, 4'd6);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk1("bp.valid4", out_valid, 1'b1);
        chk64("bp.result4", out_result, 64'd99);
        chk4("bp.tag4", out_tag, 4'd7);
        chk1("bp.carry4", out_carry, 1'b1);
        @(negedge clk);
        chk1("bp.valid5", out_valid, 1'b1);
        chk64("bp.result5", out_result, 64'h77);
        chk4("bp.tag5", out_tag, 4'd8);
        @(negedge clk);
        chk1("bp.drained", out_valid, 1'b0);

        // Reset with S1 and S2 both full.
        out_ready = 1'b0;
        drive(ADD, 1'b1, 1'b0, 64'd1, 64'd1, 32'd0, 4'd9);
        @(negedge clk);
        drive(SUB, 1'b1, 1'b0, 64'd8, 64'd3, 32'd0, 4'd10);
        @(negedge clk);
        in_valid = 1'b0;
        chk1("pre_rst.out_valid", out_valid, 1'b1);
        chk1("pre_rst.in_ready", in_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk1("mid_rst.out_valid", out_valid, 1'b0);
        chk1("mid_rst.in_ready", in_ready, 1'b1);
        chk64("mid_rst.out_result", out_result, 64'd0);
        chk4("mid_rst.out_tag", out_tag, 4'd0);
        chk64("mid_rst.add_a", add_a, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1("post_rst.out_valid", out_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
